pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: maximum MEM_WAIT cycles before the error state.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-005 ex_memread  in  1  instruction in EX is a load.
REQ-006 ex_wn  in  5  destination register of the instruction in EX.
REQ-007 mem_req  in  1  instruction in MEM accesses data memory.
REQ-008 mem_ack  in  1  data memory completes the access this cycle.
REQ-009 br_taken  in  1  branch/jump resolved taken in EX.
REQ-010 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  load enables for PC and the four pipeline registers.
REQ-011 ifid_flush, idex_flush  out  1 each  load a bubble (NOP) into IF_ID / ID_EX.
REQ-012 memwb_bubble  out  1  MEM_WB loads a bubble (write-back disabled).
REQ-013 mem_err  out  1  sticky memory-timeout error.
REQ-014 stall_cnt  out  16  count of cycles with pc_en=0.

Function
REQ-015 FSM states: RUN, MEM_WAIT, ERR; outputs are decoded from state and current inputs (same-cycle).
REQ-016 load_use = ex_memread & (ex_wn!=0) & (ex_wn==id_rs | ex_wn==id_rt).
REQ-017 mem_miss = mem_req & ~mem_ack.
REQ-018 Priority in RUN: mem_miss > br_taken > load_use > normal.
REQ-019 RUN normal: all enables 1, all flushes 0, memwb_bubble 0.
REQ-020 RUN mem_miss: pc/ifid/idex/exmem enables 0, memwb_en 1, memwb_bubble 1; next state MEM_WAIT; wait counter cleared.
REQ-021 RUN br_taken (no mem_miss): all enables 1, ifid_flush 1, idex_flush 1; load_use ignored that cycle.
REQ-022 RUN load_use (no mem_miss, no br_taken): pc_en 0, ifid_en 0, idex_flush 1, exmem_en 1, memwb_en 1; exactly one bubble per hazard.
REQ-023 MEM_WAIT without mem_ack: all four register enables and pc_en 0, memwb_en 1, memwb_bubble 1; wait counter increments; br_taken and load_use ignored.
REQ-024 MEM_WAIT with mem_ack: outputs as RUN with mem_miss forced 0 (br_taken/load_use evaluated); next state RUN.
REQ-025 MEM_WAIT, wait counter reaching MEM_TIMEOUT-1 without mem_ack: next state ERR; mem_ack on that same cycle wins (to RUN).
REQ-026 ERR: all enables 0, flushes 0, memwb_bubble 0, mem_err 1; exit only by reset.
REQ-027 stall_cnt increments every cycle pc_en=0 out of reset, saturates at 16'hFFFF.
REQ-028 mem_ack in RUN without mem_req is ignored.

Reset
REQ-029 rst low: state RUN, wait counter 0, stall_cnt 0, mem_err 0, immediately, independent of clk.
REQ-030 While rst low all enables, flushes and memwb_bubble are 0.
REQ-031 Reset mid-MEM_WAIT or in ERR returns to RUN; first post-reset cycle behaves per REQ-019..022.

Structure
REQ-032 Package pipe_ctrl_pkg holds the state enumeration, MEM_TIMEOUT default and the register-zero constant.
REQ-033 One sub-module, hazard_detect: combinational load-use comparator (REQ-016).
REQ-034 Wait counter width is $clog2(MEM_TIMEOUT)+1 bits.

Verification
REQ-035 ex_memread=1, ex_wn=5, id_rs=5 in RUN -> one cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cnt 0->1.
REQ-036 ex_memread=1, ex_wn=0, id_rs=0 -> no stall, all enables 1.
REQ-037 mem_req=1, mem_ack low 3 cycles then high -> 3 frozen cycles with memwb_bubble=1, release on ack cycle, stall_cnt=3.
REQ-038 mem_req=1, br_taken=1, load_use=1 same cycle -> mem_miss wins; on ack cycle with br_taken=1 -> ifid_flush=idex_flush=1.
REQ-039 MEM_TIMEOUT=4, mem_ack never -> ERR after 4 wait cycles, mem_err=1 held; rst low -> mem_err 0 asynchronously, state RUN.
REQ-040 Force 70000 stall cycles -> stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  localparam int unsigned MEM_TIMEOUT_DEF = 16;
  localparam int unsigned REG_W           = 5;
  localparam int unsigned STALL_W         = 16;
  localparam int unsigned STATE_W         = 2;

  localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);

  localparam logic [STATE_W-1:0] ST_RUN      = 2'd0;
  localparam logic [STATE_W-1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [STATE_W-1:0] ST_ERR      = 2'd2;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX writes a register the ID instruction reads.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_wn,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             load_use_c
);

  // Register zero is hardwired, so a load targeting it never creates a hazard.
  assign load_use_c = ex_memread && (ex_wn != REG_ZERO) &&
                      ((ex_wn == id_rs) || (ex_wn == id_rt));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, branch flushes, memory-wait
// freeze with timeout to a sticky error state, and a saturating stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               ex_memread,
  input  logic [REG_W-1:0]   ex_wn,
  input  logic               mem_req,
  input  logic               mem_ack,
  input  logic               br_taken,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               idex_en,
  output logic               exmem_en,
  output logic               memwb_en,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic               memwb_bubble,
  output logic               mem_err,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic [CNT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]   wait_cnt_nxt;
  logic               load_use_c;
  logic               mem_miss_c;
  logic               run_c;
  logic               freeze_c;

  hazard_detect u_hazard_detect (
    .ex_memread (ex_memread),
    .ex_wn      (ex_wn),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .load_use_c (load_use_c)
  );

  assign mem_miss_c = mem_req && !mem_ack;

  // State and memory-wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next state plus same-cycle decode of enables/flushes.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    run_c        = 1'b0;
    freeze_c     = 1'b0;
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    memwb_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    mem_err      = 1'b0;

    case (state)
      ST_RUN: begin
        if (mem_miss_c) begin
          freeze_c     = 1'b1;
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = '0;
        end else begin
          run_c = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // An ack on the timeout cycle still completes the access.
        if (mem_ack) begin
          run_c     = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          freeze_c = 1'b1;
          if (wait_cnt == CNT_LAST) begin
            state_nxt = ST_ERR;
          end else begin
            wait_cnt_nxt = wait_cnt + CNT_W'(1);
          end
        end
      end
      ST_ERR: begin
        mem_err = 1'b1;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase

    if (freeze_c) begin
      memwb_en     = 1'b1;
      memwb_bubble = 1'b1;
    end

    // Branch flush outranks load-use: the stalled instruction is being discarded.
    if (run_c) begin
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      idex_en  = 1'b1;
      if (br_taken) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use_c) begin
        idex_flush = 1'b1;
      end else begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
      end
    end

    if (!rst) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_en     = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      memwb_bubble = 1'b0;
    end
  end

  // Saturating count of cycles with the PC held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

endmodule
